load_store_unit: RTL and testbench

//  MEM-stage front end for data_mem. Takes MIPS load/store requests on byte addresses and

---
 rtl/lsu_pkg.sv | 48 ++++
 rtl/load_store_unit_if.sv | 32 +++
 rtl/lsu_lane_mux.sv | 61 ++++++
 rtl/load_store_unit.sv | 139 +++++++++++++
 tb/tb_load_store_unit.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and helpers for the MEM-stage load/store unit.
//   lsu_op_t    : request opcode encoding (LW..SH)
//   lsu_state_t : controller state encoding
//   is_load / is_store / is_misaligned : opcode and alignment classification
package lsu_pkg;

   typedef enum logic [2:0] {
      OP_LW  = 3'd0,
      OP_LB  = 3'd1,
      OP_LBU = 3'd2,
      OP_LH  = 3'd3,
      OP_LHU = 3'd4,
      OP_SW  = 3'd5,
      OP_SB  = 3'd6,
      OP_SH  = 3'd7
   } lsu_op_t;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD   = 3'd1,
      S_WRITE  = 3'd2,
      S_RMW_RD = 3'd3,
      S_RMW_WR = 3'd4,
      S_RESP   = 3'd5
   } lsu_state_t;

   function automatic logic is_load(input lsu_op_t op);
      return (op == OP_LW) || (op == OP_LB) || (op == OP_LBU) ||
             (op == OP_LH) || (op == OP_LHU);
   endfunction

   function automatic logic is_store(input lsu_op_t op);
      return (op == OP_SW) || (op == OP_SB) || (op == OP_SH);
   endfunction

   // Words need both low address bits clear, halves need bit 0 clear,
   // bytes can never be misaligned.
   function automatic logic is_misaligned(input lsu_op_t op, input logic [1:0] a);
      logic m;
      case (op)
         OP_LW, OP_SW:         m = (a != 2'b00);
         OP_LH, OP_LHU, OP_SH: m = a[0];
         default:              m = 1'b0;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// load_store_unit_if: request/response bus between the pipeline and the LSU.
//   req_valid/req_ready : request handshake (accepted when both high)
//   req_op/addr/wdata   : opcode, byte address, right-aligned store data
//   rsp_valid           : one-cycle completion pulse
//   rsp_rdata/rsp_err   : extended load data / misalignment flag
// modports: master = pipeline side, slave = LSU side.
interface load_store_unit_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 32
);
   import lsu_pkg::*;

   logic              req_valid;
   logic              req_ready;
   lsu_op_t           req_op;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;

   modport master (
      output req_valid, req_op, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_op, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );

endinterface

// File: rtl/lsu_lane_mux.sv
// lsu_lane_mux: combinational byte-lane logic of the load/store unit.
//   rd_word_i : word read from data memory
//   wdata_i   : right-aligned store data
//   offset_i  : byte offset within the word (addr[1:0])
//   op_i      : request opcode
//   ld_data_o : selected lane, sign/zero-extended (0 for stores)
//   st_word_o : rd_word_i with the addressed byte/half replaced (SW: wdata_i)
// BIG_ENDIAN mirrors the lane numbering: byte k -> lane 3-k, half h -> lane 1-h.
module lsu_lane_mux
   import lsu_pkg::*;
#(
   parameter int unsigned DATA_W     = 32,
   parameter bit          BIG_ENDIAN = 1'b0
) (
   input  logic [DATA_W-1:0] rd_word_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [1:0]        offset_i,
   input  lsu_op_t           op_i,
   output logic [DATA_W-1:0] ld_data_o,
   output logic [DATA_W-1:0] st_word_o
);

   logic [1:0]  byte_lane;
   logic        half_lane;
   logic [4:0]  byte_sh;
   logic [4:0]  half_sh;
   logic [7:0]  rd_byte;
   logic [15:0] rd_half;

   always_comb begin
      byte_lane = BIG_ENDIAN ? (2'd3 - offset_i) : offset_i;
      half_lane = BIG_ENDIAN ? ~offset_i[1] : offset_i[1];
      byte_sh   = {byte_lane, 3'b000};
      half_sh   = {half_lane, 4'b0000};
      rd_byte   = rd_word_i[byte_sh +: 8];
      rd_half   = rd_word_i[half_sh +: 16];
   end

   always_comb begin
      ld_data_o = '0;
      case (op_i)
         OP_LW:   ld_data_o = rd_word_i;
         OP_LB:   ld_data_o = {{(DATA_W-8){rd_byte[7]}}, rd_byte};
         OP_LBU:  ld_data_o = {{(DATA_W-8){1'b0}}, rd_byte};
         OP_LH:   ld_data_o = {{(DATA_W-16){rd_half[15]}}, rd_half};
         OP_LHU:  ld_data_o = {{(DATA_W-16){1'b0}}, rd_half};
         default: ld_data_o = '0;
      endcase
   end

   always_comb begin
      st_word_o = rd_word_i;
      case (op_i)
         OP_SW:   st_word_o = wdata_i;
         OP_SB:   st_word_o[byte_sh +: 8]  = wdata_i[7:0];
         OP_SH:   st_word_o[half_sh +: 16] = wdata_i[15:0];
         default: st_word_o = rd_word_i;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: MEM-stage front end for a word-addressed data memory.
//   clk, rst_n   : rising-edge clock, asynchronous active-low reset
//   bus (slave)  : request/response handshake, see load_store_unit_if
//   mem_addr_o   : word address {2'b00, addr[ADDR_W-1:2]}
//   mem_w_data_o : write word
//   mem_w_ena_o  : write enable (only in WRITE and RMW_WR)
//   mem_r_data_i : read word, combinational from mem_addr_o
// One request in flight. Loads, SW and misaligned requests answer two cycles
// after acceptance, SB/SH three cycles after (read-modify-write).
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned ADDR_W     = 32,
   parameter bit          BIG_ENDIAN = 1'b0
) (
   input  logic              clk,
   input  logic              rst_n,
   load_store_unit_if.slave  bus,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_w_data_o,
   output logic              mem_w_ena_o,
   input  logic [DATA_W-1:0] mem_r_data_i
);

   lsu_state_t        state_q;
   lsu_op_t           op_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic              err_pend_q;
   logic              ready_q;
   logic              rsp_valid_q;
   logic [DATA_W-1:0] rsp_rdata_q;
   logic              rsp_err_q;
   logic              w_ena_q;
   logic [DATA_W-1:0] w_data_q;

   logic [DATA_W-1:0] ld_data_d;
   logic [DATA_W-1:0] st_word_d;

   lsu_lane_mux #(
      .DATA_W     (DATA_W),
      .BIG_ENDIAN (BIG_ENDIAN)
   ) u_lane_mux (
      .rd_word_i (mem_r_data_i),
      .wdata_i   (wdata_q),
      .offset_i  (addr_q[1:0]),
      .op_i      (op_q),
      .ld_data_o (ld_data_d),
      .st_word_o (st_word_d)
   );

   // Misaligned requests pass through LOAD (no write, read data discarded)
   // so that their response lands on the same cycle as an aligned load.
   // The RMW merge result is captured straight into w_data_q at the end of
   // RMW_RD, which therefore doubles as the merge buffer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         op_q        <= OP_LW;
         addr_q      <= '0;
         wdata_q     <= '0;
         err_pend_q  <= 1'b0;
         ready_q     <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
         w_ena_q     <= 1'b0;
         w_data_q    <= '0;
      end else begin
         rsp_valid_q <= 1'b0;
         w_ena_q     <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (bus.req_valid) begin
                  op_q       <= bus.req_op;
                  addr_q     <= bus.req_addr;
                  wdata_q    <= bus.req_wdata;
                  ready_q    <= 1'b0;
                  err_pend_q <= 1'b0;
                  if (is_misaligned(bus.req_op, bus.req_addr[1:0])) begin
                     err_pend_q <= 1'b1;
                     state_q    <= S_LOAD;
                  end else if (is_load(bus.req_op)) begin
                     state_q <= S_LOAD;
                  end else if (bus.req_op == OP_SW) begin
                     w_ena_q  <= 1'b1;
                     w_data_q <= bus.req_wdata;
                     state_q  <= S_WRITE;
                  end else begin
                     state_q <= S_RMW_RD;
                  end
               end
            end
            S_LOAD: begin
               rsp_rdata_q <= err_pend_q ? '0 : ld_data_d;
               rsp_err_q   <= err_pend_q;
               rsp_valid_q <= 1'b1;
               state_q     <= S_RESP;
            end
            S_WRITE: begin
               rsp_rdata_q <= '0;
               rsp_err_q   <= 1'b0;
               rsp_valid_q <= 1'b1;
               state_q     <= S_RESP;
            end
            S_RMW_RD: begin
               w_data_q <= st_word_d;
               w_ena_q  <= 1'b1;
               state_q  <= S_RMW_WR;
            end
            S_RMW_WR: begin
               rsp_rdata_q <= '0;
               rsp_err_q   <= 1'b0;
               rsp_valid_q <= 1'b1;
               state_q     <= S_RESP;
            end
            S_RESP: begin
               ready_q <= 1'b1;
               state_q <= S_IDLE;
            end
            default: begin
               ready_q <= 1'b1;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.req_ready = ready_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rsp_rdata_q;
   assign bus.rsp_err   = rsp_err_q;

   assign mem_addr_o   = {2'b00, addr_q[ADDR_W-1:2]};
   assign mem_w_data_o = w_data_q;
   assign mem_w_ena_o  = w_ena_q;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
   import lsu_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc = cyc + 1;

   int checks = 0;
   int failures = 0;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         failures = failures + 1;
         $display("FAIL %s actual=0x%08h expected=0x%08h (t=%0t)", name, act, exp, $time);
      end
   endfunction

   // ---------------- DUT 0: little endian ----------------
   load_store_unit_if #(.DATA_W(32), .ADDR_W(32)) bus0 ();
   logic [31:0] mem_addr0, mem_w_data0, mem_r_data0;
   logic        mem_w_ena0;
   logic [31:0] mem0 [0:15];

   load_store_unit #(.DATA_W(32), .ADDR_W(32), .BIG_ENDIAN(1'b0)) dut0 (
      .clk          (clk),
      .rst_n        (rst_n),
      .bus          (bus0),
      .mem_addr_o   (mem_addr0),
      .mem_w_data_o (mem_w_data0),
      .mem_w_ena_o  (mem_w_ena0),
      .mem_r_data_i (mem_r_data0)
   );

   assign mem_r_data0 = mem0[mem_addr0[3:0]];
   always @(posedge clk) if (mem_w_ena0) mem0[mem_addr0[3:0]] = mem_w_data0;

   // ---------------- DUT 1: big endian ----------------
   load_store_unit_if #(.DATA_W(32), .ADDR_W(32)) bus1 ();
   logic [31:0] mem_addr1, mem_w_data1, mem_r_data1;
   logic        mem_w_ena1;
   logic [31:0] mem1 [0:15];

   load_store_unit #(.DATA_W(32), .ADDR_W(32), .BIG_ENDIAN(1'b1)) dut1 (
      .clk          (clk),
      .rst_n        (rst_n),
      .bus          (bus1),
      .mem_addr_o   (mem_addr1),
      .mem_w_data_o (mem_w_data1),
      .mem_w_ena_o  (mem_w_ena1),
      .mem_r_data_i (mem_r_data1)
   );

   assign mem_r_data1 = mem1[mem_addr1[3:0]];
   always @(posedge clk) if (mem_w_ena1) mem1[mem_addr1[3:0]] = mem_w_data1;

   // ---------------- scoreboard for DUT 0 ----------------
   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          cyc;
   } exp_t;
   exp_t q0[$];

   int wcount = 0;
   int last_w_cyc = -1;
   logic [31:0] last_w_addr = '0;

   always @(negedge clk) begin : mon0
      exp_t e;
      if (rst_n) begin
         if (mem_w_ena0) begin
            wcount      = wcount + 1;
            last_w_cyc  = cyc;
            last_w_addr = mem_addr0;
         end
         if (bus0.rsp_valid) begin
            if (q0.size() == 0) begin
               chk("unexpected_rsp_valid", 32'd1, 32'd0);
            end else begin
               e = q0.pop_front();
               chk("rsp_rdata", bus0.rsp_rdata, e.rdata);
               chk("rsp_err", {31'd0, bus0.rsp_err}, {31'd0, e.err});
               chk("rsp_cycle", cyc, e.cyc);
            end
         end
      end
   end

   typedef struct {
      lsu_op_t     op;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
      int          lat;
      bit          chk_mem;
      int          widx;
      logic [31:0] exp_word;
   } vec_t;

   vec_t vecs [16];

   task automatic wait_ready0();
      int n;
      n = 0;
      @(negedge clk);
      while (!bus0.req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!bus0.req_ready) chk("ready_timeout", {31'd0, bus0.req_ready}, 32'd1);
   endtask

   task automatic issue0(input vec_t v, input bit push, output int acc);
      wait_ready0();
      bus0.req_valid = 1'b1;
      bus0.req_op    = v.op;
      bus0.req_addr  = v.addr;
      bus0.req_wdata = v.wdata;
      acc = cyc;
      if (push) q0.push_back('{v.exp_rdata, v.exp_err, cyc + v.lat});
      @(negedge clk);
      bus0.req_valid = 1'b0;
   endtask

   task automatic drain0();
      int n;
      n = 0;
      while (q0.size() != 0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("rsp_drain_timeout", q0.size(), 32'd0);
   endtask

   // Hand-driven request on the big-endian instance with direct response wait.
   task automatic issue1(input string name, input lsu_op_t op, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_rdata, input int lat);
      int n;
      int c;
      n = 0;
      @(negedge clk);
      while (!bus1.req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!bus1.req_ready) chk("be_ready_timeout", {31'd0, bus1.req_ready}, 32'd1);
      bus1.req_valid = 1'b1;
      bus1.req_op    = op;
      bus1.req_addr  = addr;
      bus1.req_wdata = wdata;
      c = cyc;
      @(negedge clk);
      bus1.req_valid = 1'b0;
      n = 0;
      while (!bus1.rsp_valid && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk({name, "_latency"}, cyc - c, lat);
      chk({name, "_rdata"}, bus1.rsp_rdata, exp_rdata);
      chk({name, "_err"}, {31'd0, bus1.rsp_err}, 32'd0);
   endtask

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog_timeout actual=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int acc;
      int wb;
      int acc_cnt;
      bit is_st;

      bus0.req_valid = 1'b0; bus0.req_op = OP_LW; bus0.req_addr = '0; bus0.req_wdata = '0;
      bus1.req_valid = 1'b0; bus1.req_op = OP_LW; bus1.req_addr = '0; bus1.req_wdata = '0;
      for (int i = 0; i < 16; i++) begin
         mem0[i] = '0;
         mem1[i] = '0;
      end
      mem0[1] = 32'hDEADBEEF;
      mem0[2] = 32'hAABBCCDD;
      mem0[8] = 32'h80FF7F01;
      mem1[0] = 32'h11223344;

      vecs[0]  = '{OP_SW,  32'h10, 32'h12345678, 32'h00000000, 1'b0, 2, 1'b1, 4, 32'h12345678};
      vecs[1]  = '{OP_LW,  32'h10, 32'h0,        32'h12345678, 1'b0, 2, 1'b0, 0, 32'h0};
      vecs[2]  = '{OP_LB,  32'h23, 32'h0,        32'hFFFFFF80, 1'b0, 2, 1'b0, 0, 32'h0};
      vecs[3]  = '{OP_LBU, 32'h23, 32'h0,        32'h00000080, 1'b0, 2, 1'b0, 0, 32'h0};
      vecs[4]  = '{OP_LH,  32'h22, 32'h0,        32'hFFFF80FF, 1'b0, 2, 1'b0, 0, 32'h0};
      vecs[5]  = '{OP_LHU, 32'h20, 32'h0,        32'h00007F01, 1'b0, 2, 1'b0, 0, 32'h0};
      vecs[6]  = '{OP_LB,  32'h21, 32'h0,        32'h0000007F, 1'b0, 2, 1'b0, 0, 32'h0};
      vecs[7]  = '{OP_SB,  32'h09, 32'h00000011, 32'h00000000, 1'b0, 3, 1'b1, 2, 32'hAABB11DD};
      vecs[8]  = '{OP_SH,  32'h0A, 32'h00002233, 32'h00000000, 1'b0, 3, 1'b1, 2, 32'h223311DD};
      vecs[9]  = '{OP_LW,  32'h06, 32'h0,        32'h00000000, 1'b1, 2, 1'b1, 1, 32'hDEADBEEF};
      vecs[10] = '{OP_SH,  32'h03, 32'h0000FFFF, 32'h00000000, 1'b1, 2, 1'b1, 0, 32'h00000000};
      vecs[11] = '{OP_SW,  32'h02, 32'hFFFFFFFF, 32'h00000000, 1'b1, 2, 1'b1, 0, 32'h00000000};
      vecs[12] = '{OP_LH,  32'h01, 32'h0,        32'h00000000, 1'b1, 2, 1'b0, 0, 32'h0};
      vecs[13] = '{OP_SB,  32'h03, 32'hFFFFFF77, 32'h00000000, 1'b0, 3, 1'b1, 0, 32'h77000000};
      vecs[14] = '{OP_LHU, 32'h02, 32'h0,        32'h00007700, 1'b0, 2, 1'b0, 0, 32'h0};
      vecs[15] = '{OP_LB,  32'h03, 32'h0,        32'h00000077, 1'b0, 2, 1'b0, 0, 32'h0};

      // Reset values
      repeat (2) @(negedge clk);
      chk("reset_req_ready", {31'd0, bus0.req_ready}, 32'd1);
      chk("reset_rsp_valid", {31'd0, bus0.rsp_valid}, 32'd0);
      chk("reset_rsp_rdata", bus0.rsp_rdata, 32'd0);
      chk("reset_rsp_err", {31'd0, bus0.rsp_err}, 32'd0);
      chk("reset_mem_w_ena", {31'd0, mem_w_ena0}, 32'd0);
      chk("reset_mem_addr", mem_addr0, 32'd0);
      chk("reset_mem_w_data", mem_w_data0, 32'd0);
      rst_n = 1'b1;

      // Table-driven vectors on the little-endian instance
      for (int i = 0; i < 16; i++) begin
         wb = wcount;
         is_st = (vecs[i].op == OP_SW) || (vecs[i].op == OP_SB) || (vecs[i].op == OP_SH);
         issue0(vecs[i], 1'b1, acc);
         drain0();
         if (is_st && !vecs[i].exp_err) begin
            chk("write_count", wcount - wb, 32'd1);
            chk("write_cycle", last_w_cyc, acc + vecs[i].lat - 1);
            chk("write_addr", last_w_addr, {2'b00, vecs[i].addr[31:2]});
         end else begin
            chk("no_write", wcount - wb, 32'd0);
         end
         if (vecs[i].chk_mem) chk("mem_word", mem0[vecs[i].widx], vecs[i].exp_word);
      end

      // Reset during RMW_WR kills the write and the response
      wait_ready0();
      bus0.req_valid = 1'b1;
      bus0.req_op    = OP_SB;
      bus0.req_addr  = 32'h4;
      bus0.req_wdata = 32'h55;
      @(negedge clk);
      bus0.req_valid = 1'b0;
      @(negedge clk);
      chk("rmw_wr_w_ena", {31'd0, mem_w_ena0}, 32'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("async_kill_w_ena", {31'd0, mem_w_ena0}, 32'd0);
      chk("async_rst_ready", {31'd0, bus0.req_ready}, 32'd1);
      chk("async_rst_rsp_valid", {31'd0, bus0.rsp_valid}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("killed_write_mem", mem0[1], 32'hDEADBEEF);
      chk("post_rst_ready", {31'd0, bus0.req_ready}, 32'd1);

      // Back-to-back with req_valid held: accepted only in IDLE, every third cycle
      wait_ready0();
      bus0.req_valid = 1'b1;
      bus0.req_op    = OP_LW;
      bus0.req_addr  = 32'h10;
      bus0.req_wdata = 32'h0;
      acc_cnt = 1;
      q0.push_back('{32'h12345678, 1'b0, cyc + 2});
      q0.push_back('{32'h12345678, 1'b0, cyc + 5});
      q0.push_back('{32'h12345678, 1'b0, cyc + 8});
      for (int i = 1; i < 9; i++) begin
         @(negedge clk);
         if (bus0.req_ready) acc_cnt++;
      end
      @(negedge clk);
      bus0.req_valid = 1'b0;
      chk("b2b_accepts", acc_cnt, 32'd3);
      drain0();

      // Big-endian instance
      issue1("be_lbu0", OP_LBU, 32'h0, 32'h0,  32'h00000011, 2);
      issue1("be_lb2",  OP_LB,  32'h2, 32'h0,  32'h00000033, 2);
      issue1("be_lh0",  OP_LH,  32'h0, 32'h0,  32'h00001122, 2);
      issue1("be_sb3",  OP_SB,  32'h3, 32'hEE, 32'h00000000, 3);
      chk("be_sb3_mem", mem1[0], 32'h112233EE);
      issue1("be_lhu2", OP_LHU, 32'h2, 32'h0,  32'h000033EE, 2);

      repeat (3) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
